// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator with an integrated direct-mapped branch target buffer.
// Holds the architectural fetch PC and predicts the next one from the BTB target and the BHT direction.
module fetch_pc_gen #(
  parameter int          BTB_INDEX_BITS = 4,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_F,
  input  logic        predict_taken_F,
  input  logic        redirect_E,
  input  logic [31:0] redirect_pc_E,
  input  logic        btb_update_en,
  input  logic [31:0] btb_update_pc_E,
  input  logic [31:0] btb_update_target_E,
  output logic [31:0] PC_F,
  output logic [31:0] PCPlus4_F,
  output logic        btb_hit_F,
  output logic        predicted_taken_F,
  output logic [31:0] pred_target_F
);

  localparam int ENTRIES  = 1 << BTB_INDEX_BITS;
  localparam int TAG_BITS = 32 - BTB_INDEX_BITS - 2;
  localparam int TAG_LSB  = BTB_INDEX_BITS + 2;

  typedef logic [BTB_INDEX_BITS-1:0] btb_idx_t;
  typedef logic [TAG_BITS-1:0]       btb_tag_t;

  typedef enum logic [1:0] {
    SEL_REDIRECT,
    SEL_HOLD,
    SEL_PREDICT,
    SEL_SEQUENTIAL
  } next_sel_e;

  // BTB storage: valid bits are resettable flops, tag/target are plain arrays.
  logic [ENTRIES-1:0] btb_valid;
  btb_tag_t           btb_tag    [ENTRIES];
  logic [31:2]        btb_target [ENTRIES];

  btb_idx_t  lookup_idx;
  btb_tag_t  lookup_tag;
  btb_idx_t  update_idx;
  btb_tag_t  update_tag;
  next_sel_e next_sel;
  logic [31:0] next_pc;

  // Byte-offset bits of the update addresses carry no information for a word-aligned BTB.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, btb_update_pc_E[1:0], btb_update_target_E[1:0]};

  assign lookup_idx = PC_F[TAG_LSB-1:2];
  assign lookup_tag = PC_F[31:TAG_LSB];
  assign update_idx = btb_update_pc_E[TAG_LSB-1:2];
  assign update_tag = btb_update_pc_E[31:TAG_LSB];

  // Asynchronous lookup: a write this cycle is only seen from the next cycle on.
  assign PCPlus4_F         = PC_F + 32'd4;
  assign btb_hit_F         = btb_valid[lookup_idx] && (btb_tag[lookup_idx] == lookup_tag);
  assign predicted_taken_F = btb_hit_F & predict_taken_F;
  assign pred_target_F     = btb_hit_F ? {btb_target[lookup_idx], 2'b00} : PCPlus4_F;

  always_comb begin
    // NOTE: defaults first so every path assigns next_sel/next_pc; otherwise a latch is inferred.
    next_sel = SEL_SEQUENTIAL;
    next_pc  = PCPlus4_F;
    if (redirect_E) begin
      next_sel = SEL_REDIRECT;
    end else if (stall_F) begin
      next_sel = SEL_HOLD;
    end else if (predicted_taken_F) begin
      next_sel = SEL_PREDICT;
    end

    unique case (next_sel)
      SEL_REDIRECT:   next_pc = redirect_pc_E;
      SEL_HOLD:       next_pc = PC_F;
      SEL_PREDICT:    next_pc = pred_target_F;
      SEL_SEQUENTIAL: next_pc = PCPlus4_F;
      default:        next_pc = PCPlus4_F;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of block order.
    if (rst) begin
      PC_F <= RESET_PC;
    end else begin
      PC_F <= next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (btb_update_en) begin
      btb_valid[update_idx] <= 1'b1;
    end
  end

  // NOTE: tag/target arrays are not reset; a cleared valid bit masks their contents, and
  // leaving them reset-free lets the arrays map onto plain memory.
  always_ff @(posedge clk) begin
    if (btb_update_en && !rst) begin
      btb_tag[update_idx]    <= update_tag;
      btb_target[update_idx] <= btb_update_target_E[31:2];
    end
  end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage next-PC generator with an integrated direct-mapped branch target buffer (BTB). It holds the architectural fetch PC register and drives `PC_F` to instruction memory and to the branch history table. It consumes the BHT's `predict_taken_F`, combines it with a BTB hit to select the predicted target, and accepts mispredict redirects and BTB updates from the execute stage.

## Interface
- `BTB_INDEX_BITS`, default 4: BTB has 2**BTB_INDEX_BITS entries; index is `PC[BTB_INDEX_BITS+1:2]`.
- `RESET_PC`, default 32'h0000_0000: fetch PC loaded on reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall_F`  in  1  hold `PC_F` (hazard stall).
- `predict_taken_F`  in  1  BHT direction prediction for the current `PC_F`.
- `redirect_E`  in  1  execute-stage mispredict/flush; forces the next PC.
- `redirect_pc_E`  in  32  correct next PC for the redirect.
- `btb_update_en`  in  1  write one BTB entry (resolved taken branch or jump).
- `btb_update_pc_E`  in  32  PC of the resolved branch.
- `btb_update_target_E`  in  32  resolved target address.
- `PC_F`  out  32  current fetch PC (registered).
- `PCPlus4_F`  out  32  `PC_F + 4`, modulo 2^32.
- `btb_hit_F`  out  1  valid BTB entry whose tag matches `PC_F`.
- `predicted_taken_F`  out  1  `btb_hit_F & predict_taken_F`; piped down for mispredict detection.
- `pred_target_F`  out  32  BTB target for `PC_F`, or `PCPlus4_F` on a miss.

## Operation
- BTB entry fields: `valid` (1 bit), `tag = PC[31:BTB_INDEX_BITS+2]`, and `target[31:2]`. Stored targets are word-aligned; bits [1:0] read back as 2'b00.
- Lookup is an asynchronous read indexed by `PC_F`. A hit requires both `valid` and a tag match.
- Next-PC priority, highest first:
  1. `rst` → `RESET_PC`
  2. `redirect_E` → `redirect_pc_E` (overrides `stall_F`)
  3. `stall_F` → `PC_F` unchanged
  4. `predicted_taken_F` → stored target
  5. otherwise → `PCPlus4_F`
- BTB write when `btb_update_en & !rst`:
  - Entry at the index of `btb_update_pc_E` gets `valid = 1`, the new tag, and `btb_update_target_E[31:2]`.
  - Any previous entry at that index is overwritten; there is no replacement policy.
  - The write is independent of `stall_F` and `redirect_E`, and may occur in the same cycle as either.
- Reset clears every `valid` bit. Tag and target arrays need not be reset.
- No not-taken update path: the BTB only learns targets. Direction comes solely from `predict_taken_F`.

## Timing
- Reset values: after the first edge with `rst` high:
  - `PC_F = RESET_PC`
  - `PCPlus4_F = RESET_PC + 4`
  - `btb_hit_F = 0`
  - `predicted_taken_F = 0`
  - `pred_target_F = RESET_PC + 4`
- Reset mid-operation takes effect on the next edge. A redirect or BTB update asserted in the reset cycle is discarded.
- All outputs except `PC_F` are combinational from `PC_F`, BTB contents and `predict_taken_F`, and are valid in the same cycle.
- Redirect latency: `redirect_E` high in cycle n gives `PC_F = redirect_pc_E` in cycle n+1.
- BTB update latency: a write in cycle n is visible to lookup from cycle n+1. A same-cycle lookup of the same index sees the old contents.
- Wrap-around: `PC_F = 32'hFFFF_FFFC` with no prediction gives next `PC_F = 0`.
- `stall_F` held for k cycles freezes `PC_F` for exactly k cycles. BTB writes still occur during the stall.

## Test plan
- Reset and sequential fetch, with `RESET_PC = 32'h0` and no other inputs active:
  - Release reset → `PC_F` steps 0x0, 0x4, 0x8, 0xC on successive cycles.
  - `btb_hit_F = 0` throughout.
- BTB learn then predict:
  - Update pc 0x10, target 0x40. On a later visit to 0x10 with `predict_taken_F = 1` → `btb_hit_F = 1`, `pred_target_F = 0x40`, next `PC_F = 0x40`.
  - Same visit with `predict_taken_F = 0` → next `PC_F = 0x14`.
- Aliasing: after the 0x10 entry exists, update pc 0x50 (same index, different tag), target 0x80.
  - PC 0x10 → miss.
  - PC 0x50 → hit with target 0x80.
  - Lookup in the update cycle itself → old entry.
- Priority: `stall_F = 1` and `redirect_E = 1` with `redirect_pc_E = 0x200` in the same cycle → next `PC_F = 0x200`.
  - Stall alone for 3 cycles → `PC_F` constant.
- Wrap and alignment:
  - `PC_F = 0xFFFF_FFFC` → next `PC_F = 0x0`.
  - Update target 0x123 → read-back `pred_target_F = 0x120`.
- Mid-run reset: assert `rst` with valid entries and a simultaneous update → `PC_F = RESET_PC` and all lookups miss afterwards.
